// File: rtl/posit_pipe_write_arbiter.sv
// Two-requester round-robin arbiter feeding one shared posit pipe.
// The winner's word is latched and held until the pipe acknowledges it.
module posit_pipe_write_arbiter #(
  parameter int PS = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PS-1:0] s0_write_data,
  input  logic          s0_write_req,
  output logic          s0_write_ack,
  input  logic [PS-1:0] s1_write_data,
  input  logic          s1_write_req,
  output logic          s1_write_ack,
  output logic [PS-1:0] pipe_write_data,
  output logic          pipe_write_req,
  input  logic          pipe_write_ack,
  output logic [CW-1:0] s0_count,
  output logic [CW-1:0] s1_count,
  output logic          owner
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PS-1:0] data_q,  data_d;
  logic          req_q,   req_d;
  logic          ack0_q,  ack0_d;
  logic          ack1_q,  ack1_d;
  logic [CW-1:0] cnt0_q,  cnt0_d;
  logic [CW-1:0] cnt1_q,  cnt1_d;
  logic          owner_q, owner_d;
  logic          ptr_q,   ptr_d;
  logic          grant;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant   = (s0_write_req && s1_write_req) ? ptr_q : s1_write_req;

    case (state_q)
      IDLE: begin
        if (s0_write_req || s1_write_req) begin
          owner_d = grant;
          data_d  = grant ? s1_write_data : s0_write_data;
          req_d   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (pipe_write_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          ptr_d   = ~owner_q;
          if (owner_q) begin
            ack1_d = 1'b1;
            cnt1_d = cnt1_q + CW'(1);
          end else begin
            ack0_d = 1'b1;
            cnt0_d = cnt0_q + CW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Reset wins over everything, so an in-flight word is dropped without ack or count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign pipe_write_data = data_q;
  assign pipe_write_req  = req_q;
  assign s0_write_ack    = ack0_q;
  assign s1_write_ack    = ack1_q;
  assign s0_count        = cnt0_q;
  assign s1_count        = cnt1_q;
  assign owner           = owner_q;

endmodule

// File: tb/tb_posit_pipe_write_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, and a
// randomized run against a transfer-level reference model.
module tb_posit_pipe_write_arbiter;

  localparam int PS = 16;
  // Counter width kept small so the wrap from all-ones to zero is reachable quickly.
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [PS-1:0] s0_write_data, s1_write_data;
  logic          s0_write_req, s1_write_req;
  logic          s0_write_ack, s1_write_ack;
  logic [PS-1:0] pipe_write_data;
  logic          pipe_write_req;
  logic          pipe_write_ack;
  logic [CW-1:0] s0_count, s1_count;
  logic          owner;

  int n_checks = 0;
  int n_fail   = 0;

  posit_pipe_write_arbiter #(.PS(PS), .CW(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .s0_write_data   (s0_write_data),
    .s0_write_req    (s0_write_req),
    .s0_write_ack    (s0_write_ack),
    .s1_write_data   (s1_write_data),
    .s1_write_req    (s1_write_req),
    .s1_write_ack    (s1_write_ack),
    .pipe_write_data (pipe_write_data),
    .pipe_write_req  (pipe_write_req),
    .pipe_write_ack  (pipe_write_ack),
    .s0_count        (s0_count),
    .s1_count        (s1_count),
    .owner           (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic r0, input logic [PS-1:0] d0,
                       input logic r1, input logic [PS-1:0] d1, input logic pack);
    reset          = rst;
    s0_write_req   = r0;
    s0_write_data  = d0;
    s1_write_req   = r1;
    s1_write_data  = d1;
    pipe_write_ack = pack;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          r0;
    logic [PS-1:0] d0;
    logic          r1;
    logic [PS-1:0] d1;
    logic          pack;
    logic          e_req;
    logic [PS-1:0] e_data;
    logic          e_a0;
    logic          e_a1;
    logic          e_own;
    logic [CW-1:0] e_c0;
    logic [CW-1:0] e_c1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic r0, logic [PS-1:0] d0, logic r1,
                              logic [PS-1:0] d1, logic pack, logic e_req,
                              logic [PS-1:0] e_data, logic e_a0, logic e_a1,
                              logic e_own, logic [CW-1:0] e_c0, logic [CW-1:0] e_c1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.pack = pack;
    v.e_req = e_req; v.e_data = e_data; v.e_a0 = e_a0; v.e_a1 = e_a1;
    v.e_own = e_own; v.e_c0 = e_c0; v.e_c1 = e_c1;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Tracks one transfer at a time: whether a word is being offered, whether
  // it was just delivered, who owns it, and which requester is favoured next.
  bit            m_offering, m_delivered, m_who, m_favour;
  logic [PS-1:0] m_word;
  int            m_total[2];

  task automatic model_step(input logic rst, input logic r0, input logic [PS-1:0] d0,
                            input logic r1, input logic [PS-1:0] d1, input logic pack);
    if (rst) begin
      m_offering = 0; m_delivered = 0; m_who = 0; m_favour = 0; m_word = '0;
      m_total[0] = 0; m_total[1] = 0;
    end else if (m_delivered) begin
      m_delivered = 0;
    end else if (m_offering) begin
      if (pack) begin
        m_offering  = 0;
        m_delivered = 1;
        m_total[m_who] = (m_total[m_who] + 1) % (1 << CW);
        m_favour = !m_who;
      end
    end else if (r0 || r1) begin
      m_who      = (r0 && r1) ? m_favour : r1;
      m_word     = m_who ? d1 : d0;
      m_offering = 1;
    end
  endtask

  initial begin
    int high_cnt, ack_cnt;
    logic r0, r1, pk, rs;
    logic [PS-1:0] d0, d1;

    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    check("reset_pipe_req", pipe_write_req, 0);
    check("reset_pipe_data", pipe_write_data, 0);
    check("reset_acks", {s0_write_ack, s1_write_ack}, 0);
    check("reset_counts", {s0_count, s1_count}, 0);
    check("reset_owner", owner, 0);

    // Single s0 transfer, then alternating grants with both held high.
    vecs.push_back(mk(0, 1, 16'h4A00, 0, 16'h0000, 1, 1, 16'h4A00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h4A00, 0, 16'h0000, 1, 0, 16'h4A00, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 16'h4A00, 0, 16'h0000, 1, 0, 16'h4A00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 16'h4A00, 0, 16'h0000, 1, 0, 16'h4A00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h1111, 1, 16'h2222, 1, 0, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 1, 16'h1111, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 0, 16'h1111, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 0, 16'h1111, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 1, 16'h2222, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 0, 16'h2222, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 0, 16'h2222, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 1, 16'h1111, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 0, 16'h1111, 1, 0, 0, 2, 1));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 0, 16'h1111, 0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 1, 16'h2222, 0, 0, 1, 2, 1));
    vecs.push_back(mk(0, 1, 16'h1111, 1, 16'h2222, 1, 0, 16'h2222, 0, 1, 1, 2, 2));
    vecs.push_back(mk(0, 0, 16'h1111, 0, 16'h2222, 1, 0, 16'h2222, 0, 0, 1, 2, 2));
    vecs.push_back(mk(0, 0, 16'h1111, 0, 16'h2222, 1, 0, 16'h2222, 0, 0, 1, 2, 2));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1, vecs[i].pack);
      tick();
      check($sformatf("vec%0d_req", i), pipe_write_req, vecs[i].e_req);
      check($sformatf("vec%0d_data", i), pipe_write_data, vecs[i].e_data);
      check($sformatf("vec%0d_acks", i), {s0_write_ack, s1_write_ack}, {vecs[i].e_a0, vecs[i].e_a1});
      check($sformatf("vec%0d_owner", i), owner, vecs[i].e_own);
      check($sformatf("vec%0d_counts", i), {s0_count, s1_count}, {vecs[i].e_c0, vecs[i].e_c1});
    end

    // Long stall: s1 word held through five ack-less cycles, accepted on the sixth.
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 16'h7FFF, 1'b0);
    high_cnt = 0;
    ack_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      s1_write_req = 1'b0;
      if (pipe_write_req) begin
        high_cnt++;
        check("stall_data", pipe_write_data, 16'h7FFF);
      end
      if (s1_write_ack) ack_cnt++;
      if (s0_write_ack) ack_cnt += 100;
      pipe_write_ack = pipe_write_req && (high_cnt == 6);
    end
    check("stall_req_cycles", high_cnt, 6);
    check("stall_single_ack", ack_cnt, 1);
    check("stall_s1_count", s1_count, 1);

    // Reset during SEND (with ack high) abandons the word and clears the pointer.
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 16'h0A0A, 1'b0, '0, 1'b1);
    tick();
    s0_write_req = 1'b0;
    tick();
    tick();
    check("pre_rst_s0_count", s0_count, 1);
    drive(1'b0, 1'b0, '0, 1'b1, 16'h5555, 1'b0);
    tick();
    check("pre_rst_owner", owner, 1);
    check("pre_rst_req", pipe_write_req, 1);
    drive(1'b1, 1'b0, '0, 1'b0, 16'h5555, 1'b1);
    tick();
    check("rst_send_req", pipe_write_req, 0);
    check("rst_send_acks", {s0_write_ack, s1_write_ack}, 0);
    check("rst_send_counts", {s0_count, s1_count}, 0);
    drive(1'b0, 1'b1, 16'h3C3C, 1'b1, 16'h5555, 1'b0);
    tick();
    check("post_rst_owner", owner, 0);
    check("post_rst_data", pipe_write_data, 16'h3C3C);
    tick();
    check("post_rst_no_ack", {s0_write_ack, s1_write_ack}, 0);

    // Requester data changes while its word is being offered.
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 16'h0100, 1'b0, '0, 1'b0);
    tick();
    s0_write_data = 16'h0200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_data", pipe_write_data, 16'h0100);
    end
    pipe_write_ack = 1'b1;
    tick();
    check("hold_done_data", pipe_write_data, 16'h0100);
    check("hold_done_ack", s0_write_ack, 1);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();

    // Counter wrap: (2^CW - 1) transfers, then one more.
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 16'h0ABC, 1'b0, '0, 1'b1);
    repeat (((1 << CW) - 1) * 3) tick();
    check("wrap_full", s0_count, (1 << CW) - 1);
    repeat (3) tick();
    check("wrap_zero", s0_count, 0);
    check("wrap_s1_unchanged", s1_count, 0);

    // Randomized run against the reference model.
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    model_step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(99) == 0);
      r0 = $urandom_range(2) != 0;
      r1 = $urandom_range(2) != 0;
      d0 = PS'($urandom);
      d1 = PS'($urandom);
      pk = $urandom_range(1);
      drive(rs, r0, d0, r1, d1, pk);
      model_step(rs, r0, d0, r1, d1, pk);
      tick();
      check("rnd_req", pipe_write_req, m_offering);
      check("rnd_data", pipe_write_data, m_word);
      check("rnd_ack0", s0_write_ack, m_delivered && !m_who);
      check("rnd_ack1", s1_write_ack, m_delivered && m_who);
      check("rnd_owner", owner, m_who);
      check("rnd_count0", s0_count, m_total[0]);
      check("rnd_count1", s1_count, m_total[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
